// File: rtl/reset_sequencer_if.sv
// Board-side reset inputs and sequenced domain-reset outputs of the reset sequencer.
// The master side drives the raw pins; the sequencer connects as slave.
interface reset_sequencer_if #(
  parameter int N_DOMAINS = 3
);
  logic                 ext_reset_n;
  logic                 pll_locked;
  logic [N_DOMAINS-1:0] dom_rst_n;
  logic                 all_released;
  logic                 lock_lost;
  logic [1:0]           state_o;

  modport master (
    output ext_reset_n, pll_locked,
    input  dom_rst_n, all_released, lock_lost, state_o
  );

  modport slave (
    input  ext_reset_n, pll_locked,
    output dom_rst_n, all_released, lock_lost, state_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// Conditions the board button and PLL lock, holds all domains in reset, then releases
// N_DOMAINS resets in order; any loss of button or lock drops every domain back to reset.
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int N_DOMAINS       = 3,
  parameter int GAP_CYCLES      = 8
) (
  input logic              clk,
  input logic              rst_n,
  reset_sequencer_if.slave bus
);
  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_HG > DEBOUNCE_CYCLES) ? MAX_HG : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(N_DOMAINS + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_FULL  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                              input logic [CNT_W-1:0] lim);
    return (v == lim) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] ext_sync, lock_sync;
  logic                   ext_s, lock_s;
  logic [CNT_W-1:0]       deb_cnt;
  logic                   ext_ok, ext_ok_nxt, rel_ok, lock_bad;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [N_DOMAINS-1:0] dom, dom_nxt;
  logic                 all_rel, all_nxt, lost, lost_nxt;

  assign ext_s  = ext_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];
  // Release needs a full debounce window; a single low sample drops ext_ok straight into rel_ok.
  assign ext_ok_nxt = ext_s & (ext_ok | (deb_cnt == DEB_FULL));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_sync  <= '0;
      lock_sync <= '0;
      deb_cnt   <= '0;
      ext_ok    <= 1'b0;
      rel_ok    <= 1'b0;
      lock_bad  <= 1'b0;
    end else begin
      ext_sync  <= {ext_sync[SYNC_STAGES-2:0], bus.ext_reset_n};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_locked};
      deb_cnt   <= ext_s ? sat_inc(deb_cnt, DEB_FULL) : '0;
      ext_ok    <= ext_ok_nxt;
      rel_ok    <= ext_ok_nxt & lock_s;
      lock_bad  <= ~lock_s;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    dom_nxt   = dom;
    all_nxt   = all_rel;
    lost_nxt  = lost;
    unique case (state)
      S_ASSERT: begin
        dom_nxt = '0;
        all_nxt = 1'b0;
        if (rel_ok) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = S_RELEASE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          dom_nxt   = N_DOMAINS'(1);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        // Released bits are contiguous from bit 0, so the next domain is a shift-in of a one.
        if (idx == IDX_LAST) begin
          state_nxt = S_RUN;
          dom_nxt   = '1;
          all_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          idx_nxt = idx + 1'b1;
          cnt_nxt = '0;
          dom_nxt = (dom << 1) | N_DOMAINS'(1);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        dom_nxt = '1;
        all_nxt = 1'b1;
      end
      default: state_nxt = S_ASSERT;
    endcase

    if (state != S_ASSERT && !rel_ok) begin
      state_nxt = S_ASSERT;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      dom_nxt   = '0;
      all_nxt   = 1'b0;
      if (lock_bad) lost_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_ASSERT;
      cnt     <= '0;
      idx     <= '0;
      dom     <= '0;
      all_rel <= 1'b0;
      lost    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      dom     <= dom_nxt;
      all_rel <= all_nxt;
      lost    <= lost_nxt;
    end
  end

  assign bus.dom_rst_n    = dom;
  assign bus.all_released = all_rel;
  assign bus.lock_lost    = lost;
  assign bus.state_o      = state;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a cycle-indexed model derived from pin history plus
// literal timing checks, with a second instance covering the single-domain minimal-timing case.
module tb_reset_sequencer;
  localparam int N = 3;
  localparam int H = 16;
  localparam int G = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic lck = 1'b1;

  always #5 clk = ~clk;

  reset_sequencer_if #(.N_DOMAINS(N)) bus0 ();
  reset_sequencer_if #(.N_DOMAINS(1)) bus1 ();

  assign bus0.ext_reset_n = btn;
  assign bus0.pll_locked  = lck;
  assign bus1.ext_reset_n = btn;
  assign bus1.pll_locked  = lck;

  reset_sequencer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(H),
                    .N_DOMAINS(N), .GAP_CYCLES(G)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  reset_sequencer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(1),
                    .N_DOMAINS(1), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: pin history by cycle, rel_ok derived from it, outputs from run length of rel_ok.
  bit b_h [0:2047];
  bit l_h [0:2047];
  bit rel_h [0:2047];
  bit lbad_h [0:2047];
  int vf = 0;
  bit m_valid = 0;
  int t0 = -1;
  int m_st = 0;
  int m_dom = 0;
  int m_all = 0;
  int m_lost = 0;

  initial begin
    int c, k, m, nrel;
    bit r;
    forever begin
      @(posedge clk);
      c = cyc + 1;
      b_h[c-1] = btn;
      l_h[c-1] = lck;
      if (!rst_n) begin
        vf = c;
        m_valid = 1;
      end
      // Release is seen 7 cycles after the button has been high for 5 consecutive cycles,
      // and drops 3 cycles after either pin goes low.
      r = m_valid && (c - 7 >= vf);
      if (r) begin
        for (int j = c - 7; j <= c - 3; j++) r = r && b_h[j];
        r = r && l_h[c-3];
      end
      rel_h[c] = r;
      if (c - 3 >= vf && m_valid) lbad_h[c] = !l_h[c-3];
      else lbad_h[c] = 1'b1;

      if (!rst_n) begin
        m_st = 0; m_dom = 0; m_all = 0; m_lost = 0; t0 = -1;
      end else if (!rel_h[c-1]) begin
        if (m_st != 0 && lbad_h[c-1]) m_lost = 1;
        m_st = 0; m_dom = 0; m_all = 0; t0 = -1;
      end else begin
        if (t0 < 0) t0 = c - 1;
        k = c - t0;
        if (k <= H) begin
          m_st = 1; m_dom = 0; m_all = 0;
        end else begin
          m = k - H - 1;
          if (m <= (N - 1) * G) begin
            nrel = m / G + 1;
            m_st = 2; m_dom = (1 << nrel) - 1; m_all = 0;
          end else begin
            m_st = 3; m_dom = (1 << N) - 1; m_all = 1;
          end
        end
      end
      cyc = c;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        checks++;
        if (int'(bus0.dom_rst_n) != m_dom || int'(bus0.all_released) != m_all ||
            int'(bus0.lock_lost) != m_lost || int'(bus0.state_o) != m_st) begin
          errors++;
          $display("FAIL model cyc=%0d got dom=%0d all=%0d lost=%0d st=%0d want dom=%0d all=%0d lost=%0d st=%0d",
                   cyc, bus0.dom_rst_n, bus0.all_released, bus0.lock_lost, bus0.state_o,
                   m_dom, m_all, m_lost, m_st);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic goto(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up: reset for 5 cycles, button rises at pin cycle 10 -> t0 = 17.
    goto(3);
    chk("rst_state", int'(bus0.state_o), 0);
    chk("rst_dom", int'(bus0.dom_rst_n), 0);
    chk("rst_all", int'(bus0.all_released), 0);
    chk("rst_lost", int'(bus0.lock_lost), 0);
    goto(5);  rst_n = 1'b1;
    goto(10); btn = 1'b1;
    goto(17); chk("t0_assert", int'(bus0.state_o), 0);
    goto(18); chk("one_hold", int'(bus1.state_o), 1);
              chk("one_dom_hold", int'(bus1.dom_rst_n), 0);
              chk("t0p1_hold", int'(bus0.state_o), 1);
    goto(19); chk("one_dom_rel", int'(bus1.dom_rst_n), 1);
              chk("one_release", int'(bus1.state_o), 2);
    goto(20); chk("one_run", int'(bus1.state_o), 3);
              chk("one_all", int'(bus1.all_released), 1);
    goto(33); chk("hold_end_dom", int'(bus0.dom_rst_n), 0);
    goto(34); chk("dom001", int'(bus0.dom_rst_n), 1);
    goto(41); chk("dom001_end", int'(bus0.dom_rst_n), 1);
    goto(42); chk("dom011", int'(bus0.dom_rst_n), 3);
    goto(50); chk("dom111", int'(bus0.dom_rst_n), 7);
              chk("not_yet_run", int'(bus0.state_o), 2);
    goto(51); chk("run_state", int'(bus0.state_o), 3);
              chk("run_all", int'(bus0.all_released), 1);

    // Button press from RUN, then a 2-cycle glitch while HOLD cnt=10.
    goto(60); btn = 1'b0;
    goto(63); chk("press_still_run", int'(bus0.state_o), 3);
    goto(64); chk("press_assert", int'(bus0.state_o), 0);
              chk("press_no_lost", int'(bus0.lock_lost), 0);
              btn = 1'b1;
    goto(82); chk("hold_at_10", int'(bus0.state_o), 1);
              btn = 1'b0;
    goto(84); btn = 1'b1;
    goto(85); chk("glitch_hold", int'(bus0.state_o), 1);
    goto(86); chk("glitch_assert", int'(bus0.state_o), 0);
              chk("glitch_no_lost", int'(bus0.lock_lost), 0);
    goto(91); chk("new_t0_assert", int'(bus0.state_o), 0);
    goto(92); chk("new_hold", int'(bus0.state_o), 1);
    goto(107); chk("rehold_full", int'(bus0.state_o), 1);
    goto(108); chk("rehold_dom001", int'(bus0.dom_rst_n), 1);
    goto(125); chk("rerun", int'(bus0.state_o), 3);

    // Lock loss in RUN for 10 cycles.
    goto(130); lck = 1'b0;
    goto(133); chk("lock_still_run", int'(bus0.state_o), 3);
    goto(134); chk("lock_dom0", int'(bus0.dom_rst_n), 0);
               chk("lock_lost_set", int'(bus0.lock_lost), 1);
    goto(140); lck = 1'b1;
    goto(144); chk("relock_hold", int'(bus0.state_o), 1);
    goto(177); chk("relock_run", int'(bus0.state_o), 3);
               chk("lost_sticky", int'(bus0.lock_lost), 1);

    // Block reset in RELEASE with dom=011.
    goto(185); btn = 1'b0;
    goto(187); btn = 1'b1;
    goto(219); chk("pre_rst_dom011", int'(bus0.dom_rst_n), 3);
               rst_n = 1'b0;
    goto(220); chk("mid_rst_dom", int'(bus0.dom_rst_n), 0);
               chk("mid_rst_state", int'(bus0.state_o), 0);
               chk("mid_rst_lost", int'(bus0.lock_lost), 0);
               chk("mid_rst_all", int'(bus0.all_released), 0);
               rst_n = 1'b1;
    goto(227); chk("post_rst_t0", int'(bus0.state_o), 0);
    goto(228); chk("post_rst_hold", int'(bus0.state_o), 1);

    // Bouncing button: 2 high / 2 low for 40 cycles never releases a domain.
    goto(240); btn = 1'b0;
    goto(245);
    for (int i = 0; i < 40; i++) begin
      btn = ((i / 2) % 2 == 0);
      chk("bounce_dom", int'(bus0.dom_rst_n), 0);
      @(negedge clk);
    end
    btn = 1'b1;
    goto(292); chk("bounce_t0", int'(bus0.state_o), 0);
    goto(326); chk("bounce_run", int'(bus0.state_o), 3);
    goto(335);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
